// File: rtl/control_loop_sequencer.sv
// rtl/control_loop_sequencer.sv - one pass of the flight control loop: angle, rate, mixer
// Owns stage start pulses, per-stage timeout, overrun counting and loop latency capture.
module control_loop_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LAT_WIDTH      = 16,
  parameter int OVR_WIDTH      = 8
) (
  input  logic                 us_clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 imu_update,
  input  logic                 clear_fault,
  input  logic                 ac_complete,
  input  logic                 rc_complete,
  input  logic                 mix_complete,
  output logic                 ac_start,
  output logic                 rc_start,
  output logic                 mix_start,
  output logic                 busy,
  output logic                 cycle_done,
  output logic                 fault,
  output logic [1:0]           fault_stage,
  output logic [OVR_WIDTH-1:0] overrun_count,
  output logic [LAT_WIDTH-1:0] loop_latency
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_AC_START, S_AC_WAIT, S_RC_START, S_RC_WAIT,
    S_MIX_START, S_MIX_WAIT, S_DONE, S_FAULT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TMR_W-1:0]     r_timer;
  logic [LAT_WIDTH-1:0] r_lat;
  logic                 w_timeout;
  logic                 w_in_stage;
  logic                 w_enter_start;
  logic [1:0]           w_fault_code;

  assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // Stage window: every cycle from the angle start pulse up to the mixer wait.
  assign w_in_stage = (r_state == S_AC_START) || (r_state == S_AC_WAIT) ||
                      (r_state == S_RC_START) || (r_state == S_RC_WAIT) ||
                      (r_state == S_MIX_START) || (r_state == S_MIX_WAIT);

  assign w_enter_start = (w_next == S_AC_START) || (w_next == S_RC_START) ||
                         (w_next == S_MIX_START);

  always_comb begin
    w_next       = r_state;
    w_fault_code = 2'd0;
    case (r_state)
      S_IDLE:      if (imu_update && enable) w_next = S_AC_START;
      S_AC_START:  w_next = S_AC_WAIT;
      S_AC_WAIT: begin
        if (ac_complete) begin
          w_next = S_RC_START;
        end else if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'd1;
        end
      end
      S_RC_START:  w_next = S_RC_WAIT;
      S_RC_WAIT: begin
        if (rc_complete) begin
          w_next = S_MIX_START;
        end else if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'd2;
        end
      end
      S_MIX_START: w_next = S_MIX_WAIT;
      S_MIX_WAIT: begin
        if (mix_complete) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'd3;
        end
      end
      S_DONE:      w_next = S_IDLE;
      S_FAULT:     if (clear_fault) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_next;

      // Timer reads 0 during a start cycle, so it hits TIMEOUT_CYCLES-1 on the last wait cycle.
      if (w_enter_start) begin
        r_timer <= '0;
      end else if (w_in_stage) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      if (w_next == S_AC_START) begin
        r_lat <= LAT_WIDTH'(1);
      end else if (w_in_stage && (r_lat != '1)) begin
        r_lat <= r_lat + LAT_WIDTH'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      ac_start      <= 1'b0;
      rc_start      <= 1'b0;
      mix_start     <= 1'b0;
      busy          <= 1'b0;
      cycle_done    <= 1'b0;
      fault         <= 1'b0;
      fault_stage   <= 2'd0;
      overrun_count <= '0;
      loop_latency  <= '0;
    end else begin
      ac_start   <= (w_next == S_AC_START);
      rc_start   <= (w_next == S_RC_START);
      mix_start  <= (w_next == S_MIX_START);
      cycle_done <= (w_next == S_DONE);
      fault      <= (w_next == S_FAULT);
      busy       <= (w_next != S_IDLE) && (w_next != S_FAULT);

      if (w_fault_code != 2'd0) begin
        fault_stage <= w_fault_code;
      end else if ((r_state == S_FAULT) && (w_next == S_IDLE)) begin
        fault_stage <= 2'd0;
      end

      if (imu_update && (r_state != S_IDLE) && (overrun_count != '1)) begin
        overrun_count <= overrun_count + OVR_WIDTH'(1);
      end

      if (r_state == S_DONE) begin
        loop_latency <= r_lat;
      end
    end
  end

endmodule

// File: tb/tb_control_loop_sequencer.sv
// tb/tb_control_loop_sequencer.sv - directed bench for control_loop_sequencer
// Cycle 0 of a pass is the cycle in which ac_start is high.
module tb_control_loop_sequencer;

  logic        us_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        imu_update = 1'b0;
  logic        clear_fault = 1'b0;
  logic        ac_complete = 1'b0;
  logic        rc_complete = 1'b0;
  logic        mix_complete = 1'b0;
  logic        ac_start, rc_start, mix_start, busy, cycle_done, fault;
  logic [1:0]  fault_stage;
  logic [7:0]  overrun_count;
  logic [15:0] loop_latency;

  int n_checks = 0;
  int n_errors = 0;
  int st_ac, st_rc, st_mix, st_done, f_cyc;
  int cnt_ac, cnt_rc, cnt_mix, cnt_done;

  control_loop_sequencer #(
    .TIMEOUT_CYCLES(8),
    .LAT_WIDTH(16),
    .OVR_WIDTH(8)
  ) dut (
    .us_clk(us_clk),
    .resetn(resetn),
    .enable(enable),
    .imu_update(imu_update),
    .clear_fault(clear_fault),
    .ac_complete(ac_complete),
    .rc_complete(rc_complete),
    .mix_complete(mix_complete),
    .ac_start(ac_start),
    .rc_start(rc_start),
    .mix_start(mix_start),
    .busy(busy),
    .cycle_done(cycle_done),
    .fault(fault),
    .fault_stage(fault_stage),
    .overrun_count(overrun_count),
    .loop_latency(loop_latency)
  );

  always #5 us_clk = ~us_clk;

  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drives completes at the given pass cycles (-1 = never) and logs when each output first rose.
  task automatic run_pass(input int ta, input int tr, input int tm, input int n,
                          input logic [63:0] imu_mask, input int en_off);
    st_ac = -1; st_rc = -1; st_mix = -1; st_done = -1; f_cyc = -1;
    cnt_ac = 0; cnt_rc = 0; cnt_mix = 0; cnt_done = 0;
    for (int k = 0; k < n; k++) begin
      if (ac_start)   begin cnt_ac++;   if (st_ac < 0)   st_ac = k;   end
      if (rc_start)   begin cnt_rc++;   if (st_rc < 0)   st_rc = k;   end
      if (mix_start)  begin cnt_mix++;  if (st_mix < 0)  st_mix = k;  end
      if (cycle_done) begin cnt_done++; if (st_done < 0) st_done = k; end
      if (fault && (f_cyc < 0)) f_cyc = k;
      ac_complete  = (k == ta);
      rc_complete  = (k == tr);
      mix_complete = (k == tm);
      imu_update   = imu_mask[k];
      if (k == en_off) enable = 1'b0;
      tick();
    end
    ac_complete = 1'b0; rc_complete = 1'b0; mix_complete = 1'b0; imu_update = 1'b0;
  endtask

  task automatic trigger();
    imu_update = 1'b1;
    tick();
    imu_update = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ac_start", 32'(ac_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_overrun", 32'(overrun_count), 0);
    chk("rst_latency", 32'(loop_latency), 0);
    resetn = 1'b1;
    tick();

    // 1: full pass, each complete 3 cycles after its start
    trigger();
    run_pass(3, 7, 11, 14, 64'h0, -1);
    chk("p1_ac_cycle", st_ac, 0);
    chk("p1_rc_cycle", st_rc, 4);
    chk("p1_mix_cycle", st_mix, 8);
    chk("p1_done_cycle", st_done, 12);
    chk("p1_ac_cnt", cnt_ac, 1);
    chk("p1_rc_cnt", cnt_rc, 1);
    chk("p1_mix_cnt", cnt_mix, 1);
    chk("p1_done_cnt", cnt_done, 1);
    chk("p1_latency", 32'(loop_latency), 13);
    chk("p1_busy_after", 32'(busy), 0);

    // 2: rate stage times out
    trigger();
    run_pass(1, -1, -1, 12, 64'h0, -1);
    chk("p2_rc_cycle", st_rc, 2);
    chk("p2_fault_delay", f_cyc - st_rc, 8);
    chk("p2_no_mix", cnt_mix, 0);
    chk("p2_fault", 32'(fault), 1);
    chk("p2_fault_stage", 32'(fault_stage), 2);
    chk("p2_busy_in_fault", 32'(busy), 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("p2_clr_fault", 32'(fault), 0);
    chk("p2_clr_stage", 32'(fault_stage), 0);
    chk("p2_overrun", 32'(overrun_count), 0);

    // 3: three overruns during a minimum-latency pass
    trigger();
    run_pass(1, 3, 5, 8, 64'h1C, -1);
    chk("p3_done_cycle", st_done, 6);
    chk("p3_latency", 32'(loop_latency), 7);
    chk("p3_overrun", 32'(overrun_count), 3);

    // 4: ac_complete only in AC_START, rc_complete in AC_WAIT -> angle timeout
    trigger();
    run_pass(0, 3, -1, 10, 64'h0, -1);
    chk("p4_no_rc", cnt_rc, 0);
    chk("p4_fault_cycle", f_cyc, 8);
    chk("p4_fault_stage", 32'(fault_stage), 1);
    imu_update = 1'b1;
    clear_fault = 1'b1;
    tick();
    imu_update = 1'b0;
    clear_fault = 1'b0;
    chk("p4_clr_fault", 32'(fault), 0);
    chk("p4_clr_stage", 32'(fault_stage), 0);
    chk("p4_overrun", 32'(overrun_count), 4);
    tick();
    chk("p4_not_queued", 32'(ac_start), 0);
    chk("p4_idle_busy", 32'(busy), 0);

    // 5: disabled trigger dropped; enable drop mid-pass has no effect
    enable = 1'b0;
    trigger();
    chk("p5_dis_ac", 32'(ac_start), 0);
    tick();
    chk("p5_dis_busy", 32'(busy), 0);
    chk("p5_dis_overrun", 32'(overrun_count), 4);
    enable = 1'b1;
    trigger();
    run_pass(1, 3, 5, 8, 64'h0, 3);
    enable = 1'b1;
    chk("p5_done_cnt", cnt_done, 1);
    chk("p5_done_cycle", st_done, 6);

    // overrun saturation while parked in FAULT
    trigger();
    run_pass(-1, -1, -1, 9, 64'h0, -1);
    chk("sat_fault", 32'(fault), 1);
    imu_update = 1'b1;
    repeat (300) tick();
    imu_update = 1'b0;
    chk("sat_overrun", 32'(overrun_count), 255);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;

    // 6: asynchronous reset during MIX_WAIT
    trigger();
    run_pass(1, 3, -1, 6, 64'h0, -1);
    chk("p6_mix_cycle", st_mix, 4);
    chk("p6_busy", 32'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("p6_rst_busy", 32'(busy), 0);
    chk("p6_rst_mix", 32'(mix_start), 0);
    chk("p6_rst_overrun", 32'(overrun_count), 0);
    chk("p6_rst_latency", 32'(loop_latency), 0);
    chk("p6_rst_fault", 32'(fault), 0);
    #2 resetn = 1'b1;
    tick();
    trigger();
    chk("p6_new_ac", 32'(ac_start), 1);
    tick();
    chk("p6_ac_one_cycle", 32'(ac_start), 0);
    chk("p6_busy_after", 32'(busy), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_loop_sequencer.md
Name: control_loop_sequencer

Overview:
Sequences one pass of the flight control loop: on each IMU update it starts the angle controller, then the rate controller, then the body-frame/motor mixer, each only after the previous stage reports complete. It sits between the IMU interface and the three control stages and owns their start pulses. It also provides per-stage timeout detection, overrun counting and a loop-latency measurement for debug.

Parameters:
TIMEOUT_CYCLES, 1000, maximum us_clk cycles a stage may take, measured from its start pulse to its complete, before a fault is raised.
LAT_WIDTH, 16, width of the latency measurement counter.
OVR_WIDTH, 8, width of the overrun counter.

Ports:
us_clk  input  1  system clock (1 MHz).
resetn  input  1  asynchronous, active-low reset.
enable  input  1  when 0, new triggers are ignored; a sequence already in progress runs to completion.
imu_update  input  1  single-cycle trigger pulse when fresh IMU data is valid.
clear_fault  input  1  single-cycle pulse; leaves FAULT and returns to IDLE.
ac_complete  input  1  angle controller complete.
rc_complete  input  1  rate controller complete.
mix_complete  input  1  mixer complete.
ac_start  output  1  one-cycle start pulse to the angle controller.
rc_start  output  1  one-cycle start pulse to the rate controller.
mix_start  output  1  one-cycle start pulse to the mixer.
busy  output  1  high in every state except IDLE and FAULT.
cycle_done  output  1  one-cycle pulse when the mixer completes.
fault  output  1  high while in FAULT.
fault_stage  output  2  stage that timed out: 1 = angle, 2 = rate, 3 = mixer. Holds its value until clear_fault.
overrun_count  output  OVR_WIDTH  triggers that arrived while busy or in FAULT; saturating.
loop_latency  output  LAT_WIDTH  cycles from the ac_start cycle to the cycle_done cycle of the last completed pass; saturating.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. State is IDLE. The timer and latency counter are 0.
- States: IDLE, AC_START, AC_WAIT, RC_START, RC_WAIT, MIX_START, MIX_WAIT, DONE, FAULT.
- IDLE → AC_START when imu_update && enable at a clock edge. Otherwise stay in IDLE.
- AC_START, one cycle:
  - ac_start = 1.
  - Timer cleared to 0; latency counter cleared to 1.
  - Next state is AC_WAIT.
- AC_WAIT: timer increments each cycle.
  - ac_complete sampled high → RC_START. Complete takes priority over timeout on the same edge.
  - Otherwise, timer reaches TIMEOUT_CYCLES-1 → FAULT with fault_stage = 1.
- RC_START / RC_WAIT: same as the angle stage, using rc_start, rc_complete and fault_stage = 2.
- MIX_START / MIX_WAIT: same as the angle stage, using mix_start, mix_complete and fault_stage = 3. On mix_complete the next state is DONE.
- DONE, one cycle:
  - cycle_done = 1.
  - loop_latency takes the latency counter value.
  - Next state is IDLE.
- Latency counter: increments every cycle from AC_START through MIX_WAIT and saturates at all-ones.
- Complete inputs are honoured only in their own WAIT state. A complete seen in any other state, including the START cycle, is ignored.
- FAULT:
  - fault = 1, busy = 0, no start pulses.
  - Stays in FAULT until clear_fault is sampled high; then goes to IDLE, fault = 0, fault_stage = 0.
  - imu_update and clear_fault high on the same edge in FAULT: go to IDLE only; the trigger is counted as an overrun.
- Overrun: imu_update sampled high in any state other than IDLE increments overrun_count, saturating at all-ones. The trigger is otherwise dropped; it is never queued.
- In IDLE with enable = 0, imu_update is dropped and is not counted as an overrun.
- Deasserting enable mid-sequence has no effect on the sequence in progress.
- Minimum pass latency, with each complete arriving 1 cycle after its start: ac_start to cycle_done = 7 cycles.
- resetn asserted in any state returns immediately to the reset values. Start pulses stop the same instant, asynchronously.

Test Plan:
1. TIMEOUT_CYCLES=8, enable=1. imu_update pulse; each complete returned 3 cycles after its start → ac_start, rc_start and mix_start each fire once, in order; one cycle_done; loop_latency = 13; busy drops after DONE.
2. TIMEOUT_CYCLES=8. ac_complete returned, rc_complete never asserted → fault = 1 and fault_stage = 2 exactly 8 cycles after the rc_start cycle; no mix_start; a later clear_fault pulse returns to IDLE with fault_stage = 0.
3. Three imu_update pulses during one pass and one during FAULT → overrun_count = 4. Force 300 overruns → overrun_count saturates at 255.
4. ac_complete asserted during the AC_START cycle only, never again → ignored; angle-stage timeout, fault_stage = 1. rc_complete asserted during AC_WAIT → ignored.
5. enable = 0 with an imu_update pulse → no ac_start, overrun_count unchanged. Drop enable during RC_WAIT → the pass still completes with cycle_done.
6. resetn asserted during MIX_WAIT with mix_start previously pulsed → all outputs 0 immediately. After release, a new imu_update starts a clean pass with ac_start.
